pong_match_ctrl: RTL

Match sequencer for the Pong game, clocked by the same dynamic tick as the ball-dynamics block. It consumes the one-tick goal pulses from dynamics and the Play/Pause button. It keeps both scores, gates ball motion (`run`), requests a re-centred serve with a chosen direction, and declares a winner at `WIN_SCORE`.

---
 rtl/pong_pkg.sv | 39 +++
 rtl/pong_score_counter.sv | 32 +++
 rtl/pong_match_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: match-state encoding, winner codes, screen
// constants common to the dynamics and match-control blocks, and a small
// helper for the serve-delay clamp.
package pong_pkg;

    // Match-state encoding, also exported on the debug `state` port
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_PAUSE = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SERVE = ST_SERVE,
        PLAY  = ST_PLAY,
        POINT = ST_POINT,
        PAUSE = ST_PAUSE,
        OVER  = ST_OVER
    } match_state_t;

    // Winner codes
    localparam logic [1:0] WINNER_NONE = 2'd0;
    localparam logic [1:0] WINNER_PLY1 = 2'd1;
    localparam logic [1:0] WINNER_PLY2 = 2'd2;

    // Screen geometry shared with the ball-dynamics block
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BALL_X0  = SCREEN_W / 2;
    localparam int BALL_Y0  = SCREEN_H / 2;

    // A zero serve delay would leave no SERVE cycle at all; hold for one tick
    function automatic int eff_delay(input int d);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/pong_score_counter.sv
// Saturating score counter: synchronous clear, increment enable, stops at
// LIMIT and flags when LIMIT has been reached.
module pong_score_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 9
) (
    input  logic         dyn_clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         reached
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    // Count up on inc, never past LIMIT; clear has priority
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge dyn_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT_V)) begin
            count <= count + W'(1);
        end
    end

    assign reached = (count == LIMIT_V);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: Play/Pause edge detect, serve delay, match FSM and
// two score counters. Optional feature macro PONG_AUTO_SERVE_EN: when
// defined, SERVE advances to PLAY on its own after the delay; otherwise a
// Play press is needed once the delay has expired.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 60,
    parameter int SCORE_W     = 4
) (
    input  logic               dyn_clk,
    input  logic               reset,
    input  logic               play,
    input  logic               goal_ply1,
    input  logic               goal_ply2,
    output logic               run,
    output logic               serve_req,
    output logic               serve_dir,
    output logic               reset_goals,
    output logic [SCORE_W-1:0] score_ply1,
    output logic [SCORE_W-1:0] score_ply2,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam int DELAY_EFF = eff_delay(SERVE_DELAY);
    localparam int CNT_W     = (DELAY_EFF > 1) ? $clog2(DELAY_EFF) : 1;
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_EFF - 1);

    match_state_t     state_q;
    logic             play_q;
    logic             rise_q;
    logic [CNT_W-1:0] delay_cnt;
    logic             start_match;
    logic             inc_ply1;
    logic             inc_ply2;
    logic             reached_ply1;
    logic             reached_ply2;

    // Edge detect on the button; the rise is itself registered, so a press
    // acts one tick after the edge that first samples it high
    // NOTE: only flops are reset here; there is no memory array, so the
    // async reset covers every storage element.
    always_ff @(posedge dyn_clk or posedge reset) begin
        if (reset) begin
            play_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            play_q <= play;
            rise_q <= play & ~play_q;
        end
    end

    // Score-counter controls; player 1 wins a simultaneous goal
    assign start_match = rise_q && ((state_q == IDLE) || (state_q == OVER));
    assign inc_ply1    = (state_q == PLAY) && goal_ply1;
    assign inc_ply2    = (state_q == PLAY) && goal_ply2 && !goal_ply1;

    pong_score_counter #(.W(SCORE_W), .LIMIT(WIN_SCORE)) u_score_ply1 (
        .dyn_clk (dyn_clk),
        .reset   (reset),
        .clr     (start_match),
        .inc     (inc_ply1),
        .count   (score_ply1),
        .reached (reached_ply1)
    );

    pong_score_counter #(.W(SCORE_W), .LIMIT(WIN_SCORE)) u_score_ply2 (
        .dyn_clk (dyn_clk),
        .reset   (reset),
        .clr     (start_match),
        .inc     (inc_ply2),
        .count   (score_ply2),
        .reached (reached_ply2)
    );

    // Match FSM with registered outputs and the serve delay counter
    always_ff @(posedge dyn_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            run         <= 1'b0;
            serve_req   <= 1'b0;
            serve_dir   <= 1'b1;
            reset_goals <= 1'b0;
            winner      <= WINNER_NONE;
            delay_cnt   <= '0;
        end else begin
            serve_req   <= 1'b0;
            reset_goals <= 1'b0;
            case (state_q)
                IDLE, OVER: begin
                    if (rise_q) begin
                        winner      <= WINNER_NONE;
                        reset_goals <= 1'b1;
                        serve_dir   <= 1'b1;
                        serve_req   <= 1'b1;
                        delay_cnt   <= DELAY_LOAD;
                        state_q     <= SERVE;
                    end
                end
                SERVE: begin
                    if (delay_cnt != '0) begin
                        delay_cnt <= delay_cnt - CNT_W'(1);
`ifdef PONG_AUTO_SERVE_EN
                    end else begin
`else
                    end else if (rise_q) begin
`endif
                        run     <= 1'b1;
                        state_q <= PLAY;
                    end
                end
                PLAY: begin
                    if (goal_ply1) begin
                        serve_dir <= 1'b1;
                        run       <= 1'b0;
                        state_q   <= POINT;
                    end else if (goal_ply2) begin
                        serve_dir <= 1'b0;
                        run       <= 1'b0;
                        state_q   <= POINT;
                    end else if (rise_q) begin
                        run     <= 1'b0;
                        state_q <= PAUSE;
                    end
                end
                POINT: begin
                    if (reached_ply1 || reached_ply2) begin
                        winner  <= reached_ply1 ? WINNER_PLY1 : WINNER_PLY2;
                        state_q <= OVER;
                    end else begin
                        serve_req <= 1'b1;
                        delay_cnt <= DELAY_LOAD;
                        state_q   <= SERVE;
                    end
                end
                PAUSE: begin
                    if (rise_q) begin
                        run     <= 1'b1;
                        state_q <= PLAY;
                    end
                end
                default: begin
                    run     <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule
